// File: rtl/rv32i_types.sv
// Shared front-end types: fetch FSM states, fetch packet, reset PC.
// Imported by fetch_ctrl and other front-end blocks.
package rv32i_types;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;
  localparam logic [3:0]  RMASK_WORD = 4'b1111;
  localparam logic [3:0]  RMASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    DRAIN,
    HOLD
  } fetch_ctrl_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: one imem read in flight, 1-entry hold
// buffer for queue back-pressure, squash of responses after redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = rv32i_types::RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic [3:0]      imem_rmask,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  input  logic            iq_full,
  output logic            iq_push,
  output logic [XLEN-1:0] iq_pc,
  output logic [XLEN-1:0] iq_inst,
  output logic            busy
);
  import rv32i_types::*;

  fetch_ctrl_state_t state, state_nxt;
  logic [31:0]       pc;
  logic [31:0]       req_pc;
  fetch_pkt_t        hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ISSUE: begin
        if (!redirect_valid) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_resp ? ISSUE : DRAIN;
        end else if (imem_resp) begin
          state_nxt = iq_full ? HOLD : ISSUE;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          state_nxt = ISSUE;
        end
      end
      HOLD: begin
        if (redirect_valid || !iq_full) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  // Datapath registers follow the same decisions as the state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      hold   <= '0;
    end else begin
      unique case (state)
        ISSUE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else begin
            req_pc <= pc;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (imem_resp) begin
            pc <= pc_plus4(pc);
            if (iq_full) begin
              hold.pc   <= req_pc;
              hold.inst <= imem_rdata;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc   <= redirect_pc;
            hold <= '0;
          end else if (!iq_full) begin
            hold <= '0;
          end
        end
        default: pc <= pc;
      endcase
    end
  end

  always_comb begin
    imem_addr  = '0;
    imem_rmask = RMASK_NONE;
    iq_push    = 1'b0;
    iq_pc      = '0;
    iq_inst    = '0;
    busy       = 1'b0;
    if (!rst) begin
      unique case (state)
        ISSUE: begin
          if (!redirect_valid) begin
            imem_addr  = pc;
            imem_rmask = RMASK_WORD;
          end
        end
        WAIT: begin
          busy    = 1'b1;
          iq_pc   = req_pc;
          iq_inst = imem_rdata;
          iq_push = imem_resp && !redirect_valid && !iq_full;
        end
        DRAIN: begin
          busy = 1'b1;
        end
        HOLD: begin
          iq_pc   = hold.pc;
          iq_inst = hold.inst;
          iq_push = !iq_full && !redirect_valid;
        end
        default: busy = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: the bench plays imem and queue by hand
// and checks each cycle's combinational outputs.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        iq_full = 1'b0;
  logic        iq_push;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .iq_full        (iq_full),
    .iq_push        (iq_push),
    .iq_pc          (iq_pc),
    .iq_inst        (iq_inst),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are set then.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] a);
    chk({tag, "_rmask"}, {28'd0, imem_rmask}, 32'hF);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_push"}, {31'd0, iq_push}, 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rmask"}, {28'd0, imem_rmask}, 32'h0);
    chk({tag, "_push"}, {31'd0, iq_push}, 32'd0);
  endtask

  task automatic chk_push(input string tag, input logic [31:0] p,
                          input logic [31:0] i);
    chk({tag, "_push"}, {31'd0, iq_push}, 32'd1);
    chk({tag, "_pc"}, iq_pc, p);
    chk({tag, "_inst"}, iq_inst, i);
    chk({tag, "_rmask"}, {28'd0, imem_rmask}, 32'h0);
  endtask

  initial begin
    // reset held
    cyc(); cyc(); settle();
    chk("rst_rmask", {28'd0, imem_rmask}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_push", {31'd0, iq_push}, 32'd0);
    chk("rst_pc", iq_pc, 32'h0);
    chk("rst_inst", iq_inst, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // L=1 streaming
    rst = 1'b0; settle();
    chk_issue("s0", 32'h6000_0000);
    chk("s0_busy", {31'd0, busy}, 32'd0);
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h1111_0000; settle();
    chk_push("s0r", 32'h6000_0000, 32'h1111_0000);
    chk("s0r_busy", {31'd0, busy}, 32'd1);
    cyc(); imem_resp = 1'b0; settle();
    chk_issue("s1", 32'h6000_0004);

    // back-pressure into HOLD
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h2222_0004; iq_full = 1'b1;
    settle();
    chk("h_rpush", {31'd0, iq_push}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); imem_resp = 1'b0; imem_rdata = '0; settle();
      chk_idle("h_wait");
      chk("h_busy", {31'd0, busy}, 32'd0);
    end
    cyc(); iq_full = 1'b0; settle();
    chk_push("h_out", 32'h6000_0004, 32'h2222_0004);
    cyc(); settle();
    chk_issue("s2", 32'h6000_0008);

    // redirect in WAIT, stale response drained
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h6000_0100; settle();
    chk_idle("d_redir");
    cyc(); redirect_valid = 1'b0; settle();
    chk_idle("d0");
    chk("d0_busy", {31'd0, busy}, 32'd1);
    cyc(); settle();
    chk_idle("d1");
    cyc(); imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    chk_idle("d_stale");
    cyc(); imem_resp = 1'b0; settle();
    chk_issue("d_next", 32'h6000_0100);

    // redirect coincident with response
    cyc(); imem_resp = 1'b1; imem_rdata = 32'hBAD0_0100;
    redirect_valid = 1'b1; redirect_pc = 32'h6000_0300; settle();
    chk_idle("c_drop");
    cyc(); imem_resp = 1'b0; redirect_valid = 1'b0; settle();
    chk_issue("c_next", 32'h6000_0300);

    // redirects on consecutive DRAIN cycles: last one wins
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h6000_0400; settle();
    chk_idle("dd_w");
    cyc(); redirect_pc = 32'h6000_0100; settle();
    chk_idle("dd_0");
    cyc(); redirect_pc = 32'h6000_0200; settle();
    chk_idle("dd_1");
    cyc(); redirect_valid = 1'b0; imem_resp = 1'b1; settle();
    chk_idle("dd_resp");
    cyc(); imem_resp = 1'b0; settle();
    chk_issue("dd_next", 32'h6000_0200);

    // redirect in HOLD clears the buffer without a push
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h3333_0200; iq_full = 1'b1;
    settle();
    chk("hr_rpush", {31'd0, iq_push}, 32'd0);
    cyc(); imem_resp = 1'b0; iq_full = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h6000_0500; settle();
    chk_idle("hr_redir");
    cyc(); redirect_valid = 1'b0; settle();
    chk_issue("hr_next", 32'h6000_0500);
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h4444_0500; settle();
    chk_push("hr_r", 32'h6000_0500, 32'h4444_0500);

    // redirect in ISSUE suppresses the request; then PC wrap
    cyc(); imem_resp = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    chk_idle("i_redir");
    cyc(); redirect_valid = 1'b0; settle();
    chk_issue("w0", 32'hFFFF_FFFC);
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h5555_FFFC; settle();
    chk_push("w0r", 32'hFFFF_FFFC, 32'h5555_FFFC);
    cyc(); imem_resp = 1'b0; settle();
    chk_issue("w1", 32'h0000_0000);

    // reset mid-WAIT
    cyc(); rst = 1'b1; settle();
    chk_idle("rw_rst");
    chk("rw_busy", {31'd0, busy}, 32'd0);
    cyc(); rst = 1'b0; settle();
    chk_issue("rw_next", 32'h6000_0000);
    cyc(); imem_resp = 1'b1; imem_rdata = 32'h6666_0000; settle();
    chk_push("rw_r", 32'h6000_0000, 32'h6666_0000);
    cyc(); imem_resp = 1'b0; settle();
    chk_issue("rw_n2", 32'h6000_0004);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
